// File: rtl/asym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : asym_fifo
//  Description : Asymmetric-width FIFO. Each write pushes RATIO read-width
//                words (slice 0 first); each read pops one word. The head
//                word is presented first-word-fall-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module asym_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4,
    parameter int RATIO      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic [RATIO*DATA_WIDTH-1:0]   w_data,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         r_data,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          wr_err,
    output logic                          rd_err
);

    localparam int                  c_DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_W = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_RATIO_W = (ADDR_WIDTH + 1)'(RATIO);
    localparam logic [ADDR_WIDTH:0] c_ONE_W   = (ADDR_WIDTH + 1)'(1);
    // Pointer step for a write; truncates to 0 when RATIO == DEPTH, which is
    // exactly the modulo-DEPTH behaviour wanted.
    localparam logic [ADDR_WIDTH-1:0] c_W_STEP = ADDR_WIDTH'(RATIO);

    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_w_ptr;
    logic [ADDR_WIDTH-1:0]  r_r_ptr;
    logic [ADDR_WIDTH:0]    r_count;
    logic                   r_wr_err;
    logic                   r_rd_err;

    logic [ADDR_WIDTH:0]    w_free;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic [ADDR_WIDTH:0]    w_count_next;

    // Flags and accept decisions derive only from the pre-edge occupancy, so
    // a same-cycle read never makes room for a write and vice versa.
    always_comb begin
        w_free       = c_DEPTH_W - r_count;
        w_full       = (w_free < c_RATIO_W);
        w_empty      = (r_count == '0);
        w_wr_ok      = wr & ~w_full;
        w_rd_ok      = rd & ~w_empty;
        w_count_next = r_count
                     + (w_wr_ok ? c_RATIO_W : '0)
                     - (w_rd_ok ? c_ONE_W   : '0);
    end

    // Storage write: w_ptr is always RATIO-aligned, so slices never wrap.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[r_w_ptr + ADDR_WIDTH'(k)] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointers, occupancy and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_ptr  <= '0;
            r_r_ptr  <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_w_ptr <= r_w_ptr + c_W_STEP;
            end
            if (w_rd_ok) begin
                r_r_ptr <= r_r_ptr + ADDR_WIDTH'(1);
            end
            r_count  <= w_count_next;
            r_wr_err <= wr & w_full;
            r_rd_err <= rd & w_empty;
        end
    end

    // Head word is read asynchronously; meaningless while empty.
    always_comb begin
        r_data = r_mem[r_r_ptr];
        full   = w_full;
        empty  = w_empty;
        count  = r_count;
        wr_err = r_wr_err;
        rd_err = r_rd_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_asym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asym_fifo
//  Description : Self-checking bench for asym_fifo: directed scenarios plus
//                random traffic compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asym_fifo;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int RATIO = 2;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr;
    logic [RATIO*DW-1:0]   w_data;
    logic                  rd;
    logic [DW-1:0]         r_data;
    logic                  full;
    logic                  empty;
    logic [AW:0]           count;
    logic                  wr_err;
    logic                  rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words in FIFO order plus expected error pulses.
    logic [DW-1:0] q[$];
    logic          m_wr_err = 1'b0;
    logic          m_rd_err = 1'b0;

    asym_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RATIO(RATIO)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .wr_err (wr_err),
        .rd_err (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("count",  32'(count),  32'(q.size()));
        check_val("empty",  32'(empty),  32'(q.size() == 0));
        check_val("full",   32'(full),   32'((DEPTH - q.size()) < RATIO));
        check_val("wr_err", 32'(wr_err), 32'(m_wr_err));
        check_val("rd_err", 32'(rd_err), 32'(m_rd_err));
        if (q.size() > 0) begin
            check_val("r_data", 32'(r_data), 32'(q[0]));
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare.
    task automatic step(input logic rst_i, input logic wr_i,
                        input logic [RATIO*DW-1:0] wd, input logic rd_i);
        logic m_full;
        logic m_empty;
        reset  = rst_i;
        wr     = wr_i;
        w_data = wd;
        rd     = rd_i;
        m_full  = ((DEPTH - q.size()) < RATIO);
        m_empty = (q.size() == 0);
        @(posedge clk);
        #1;
        if (rst_i) begin
            q.delete();
            m_wr_err = 1'b0;
            m_rd_err = 1'b0;
        end else begin
            if (rd_i && !m_empty) begin
                void'(q.pop_front());
            end
            if (wr_i && !m_full) begin
                for (int k = 0; k < RATIO; k++) begin
                    q.push_back(wd[k*DW +: DW]);
                end
            end
            m_wr_err = wr_i & m_full;
            m_rd_err = rd_i & m_empty;
        end
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        wr     = 1'b1;
        w_data = 8'hFF;
        rd     = 1'b0;

        // Reset held two cycles with a write pending: nothing accepted.
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        check_val("reset_count", 32'(count), 32'd0);
        check_val("reset_empty", 32'(empty), 32'd1);

        // Basic ordering: low slice first.
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        check_val("basic_first", 32'(r_data), 32'h5);
        check_val("basic_count", 32'(count), 32'd2);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("basic_second", 32'(r_data), 32'hA);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("basic_empty", 32'(empty), 32'd1);

        // Fill then drain: words emerge as 0..7.
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'h32, 1'b0);
        step(1'b0, 1'b1, 8'h54, 1'b0);
        step(1'b0, 1'b1, 8'h76, 1'b0);
        check_val("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check_val("drain_seq", 32'(r_data), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("drain_empty", 32'(empty), 32'd1);

        // Write while full, then read while empty.
        for (int i = 0; i < DEPTH / RATIO; i++) begin
            step(1'b0, 1'b1, 8'(8'h21 * (i + 1)), 1'b0);
        end
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        check_val("wr_err_pulse", 32'(wr_err), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_val("wr_err_clear", 32'(wr_err), 32'd0);
        while (q.size() > 0) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("rd_err_pulse", 32'(rd_err), 32'd1);
        step(1'b0, 1'b1, 8'h98, 1'b0);
        check_val("after_rd_err", 32'(r_data), 32'h8);

        // Near-full: count 7 is full, so wr+rd rejects the write only.
        step(1'b0, 1'b1, 8'hBA, 1'b0);
        step(1'b0, 1'b1, 8'hDC, 1'b0);
        step(1'b0, 1'b1, 8'hFE, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("near_full_cnt", 32'(count), 32'd7);
        step(1'b0, 1'b1, 8'h11, 1'b1);
        check_val("near_full_rej", 32'(count), 32'd6);
        check_val("near_full_err", 32'(wr_err), 32'd1);
        step(1'b0, 1'b1, 8'h22, 1'b1);
        check_val("near_full_both", 32'(count), 32'd7);
        while (q.size() > 0) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic, many pointer wraps, including rejected requests.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 99) < 55));
        end

        // Reset with five words stored discards them.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("pre_reset_cnt", 32'(count), 32'd5);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_val("mid_reset_cnt", 32'(count), 32'd0);
        check_val("mid_reset_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        check_val("post_reset_lo", 32'(r_data), 32'hC);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_val("post_reset_hi", 32'(r_data), 32'h3);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/asym_fifo.md
Name: asym_fifo

Overview:
Parametrised asymmetric-width FIFO. Writes push RATIO data words per cycle; reads pop one word per cycle. Word 0 of each write is the least-significant slice. It generalises the team's dual-width register file: adds depth, a configurable width ratio, read/write pointers with wrap-around, occupancy tracking, full/empty flags and error pulses. It sits between a wide producer, such as a packed bus or ADC sample pair, and a narrow consumer, such as a UART TX or display driver.

Parameters:
ADDR_WIDTH, 3, log2 of storage depth in read words (DEPTH = 2**ADDR_WIDTH).
DATA_WIDTH, 4, read-port word width in bits.
RATIO, 2, write-width/read-width ratio. Must be a power of 2 with 1 <= RATIO <= DEPTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
wr  in  1  write request.
w_data  in  RATIO*DATA_WIDTH  write data; slice k (bits [k*DATA_WIDTH +: DATA_WIDTH]) is word k.
rd  in  1  read request (pop).
r_data  out  DATA_WIDTH  head word, first-word-fall-through.
full  out  1  high when free slots < RATIO.
empty  out  1  high when count == 0.
count  out  ADDR_WIDTH+1  occupancy in read words, range 0..DEPTH.
wr_err  out  1  one-cycle pulse: wr asserted while full.
rd_err  out  1  one-cycle pulse: rd asserted while empty.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- State: storage array of DEPTH x DATA_WIDTH; w_ptr and r_ptr, each ADDR_WIDTH bits; count register; wr_err and rd_err registers.
- Reset: w_ptr=0, r_ptr=0, count=0, wr_err=0, rd_err=0, so empty=1 and full=0. Storage contents are not reset. Reset wins over wr/rd in the same cycle. Reset mid-operation discards all contents.
- Accept conditions use pre-edge state only:
  - wr_ok = wr & ~full
  - rd_ok = rd & ~empty
  - No same-cycle pass-through: a read does not free space for a same-cycle write, and a write does not satisfy a same-cycle read on an empty FIFO.
- On wr_ok: mem[w_ptr+k] <= slice k for k = 0..RATIO-1, then w_ptr <= w_ptr + RATIO (mod DEPTH).
  - w_ptr is always a multiple of RATIO, so a write never straddles the wrap boundary.
- On rd_ok: r_ptr <= r_ptr + 1 (mod DEPTH).
- count_next = count + (wr_ok ? RATIO : 0) - (rd_ok ? 1 : 0). Compute in ADDR_WIDTH+1 bits; no overflow is possible because of the accept guards.
- full = (DEPTH - count) < RATIO, combinational from count. With RATIO=1 this reduces to count == DEPTH.
- empty = (count == 0), combinational.
- r_data = mem[r_ptr], combinational (asynchronous read).
  - Valid whenever empty=0.
  - When empty=1, r_data is don't-care and the bench must not check it.
  - A written word appears on r_data the cycle after the write edge.
- wr_err <= wr & full; rd_err <= rd & empty. Each is registered and high for exactly one cycle per offending request. A rejected operation changes no pointer, count or storage.
- Latency: write-to-visible is 1 cycle. A pop takes effect at the edge; the next word is on r_data immediately after that edge.
- Ordering: strict FIFO at word granularity. Write word order is slice 0 first, then slice 1, and so on.

Test Plan:
(All with ADDR_WIDTH=3, DATA_WIDTH=4, RATIO=2, DEPTH=8.)
1. Reset: assert reset 2 cycles with wr=1, w_data=8'hFF -> empty=1, full=0, count=0, wr_err=0; no write accepted.
2. Basic order: write 8'hA5 -> next cycle count=2, r_data=4'h5; rd one cycle -> r_data=4'hA, count=1; rd again -> empty=1, count=0.
3. Fill/drain: write 8'h10, 8'h32, 8'h54, 8'h76 back-to-back -> count=8, full=1. Then 8 reads -> r_data sequence 0..7, empty=1 after the last read, rd_err=0 throughout.
4. Errors: with full=1, assert wr with 8'hEE -> wr_err pulses 1 cycle, count unchanged, subsequent reads unchanged. On empty, assert rd -> rd_err pulses 1 cycle, r_ptr unchanged.
5. Near-full simultaneous ops: reach count=7 (full=1, since 1 free < RATIO), then assert wr+rd together -> write rejected, wr_err=1, read accepted, count=6. Next cycle wr+rd -> both accepted, count=7.
6. Wrap and reset mid-op: run 20 random accepted writes and reads against a scoreboard model, crossing the pointer wrap at least twice, with every popped word matching. Then assert reset with count=5 -> count=0, empty=1; a new write 8'h3C reads back 4'hC then 4'h3.
